// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM pin-level responder.
// Covers command encodings, init states, error codes and the mode-word check.
package sdram_pkg;

    // Encoded directly as {ras_n, cas_n, we_n}.
    typedef enum logic [2:0] {
        CMD_MODE  = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_RSVD  = 3'b110,
        CMD_NOP   = 3'b111
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_WAIT_PRE,
        ST_WAIT_REF1,
        ST_WAIT_REF2,
        ST_WAIT_MODE,
        ST_READY
    } sdram_init_state_t;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_PRE_INIT   = 3'd1,
        ERR_NO_ROW     = 3'd2,
        ERR_ROW_OPEN   = 3'd3,
        ERR_OPEN_BANKS = 3'd4,
        ERR_BAD_MODE   = 3'd5
    } sdram_err_t;

    localparam int NUM_BANKS  = 4;
    localparam int PIPE_DEPTH = 3;

    // Burst length 1 with CAS latency 2 or 3 is the only supported mode.
    function automatic logic mode_ok(input logic [12:0] addr);
        return (addr[2:0] == 3'b000) && ((addr[6:4] == 3'd2) || (addr[6:4] == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_if.sv
// SDRAM command/address pins driven by the controller (master) into the device model (slave).
// The bidirectional data bus is routed as a separate port.
interface sdram_if;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_dqm;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;

    modport master (
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_dqm, sdram_ba, sdram_addr
    );

    modport slave (
        input sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input sdram_dqm, sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_read_pipe.sv
// Read-data delay line: a word enters at the READ edge and is driven on the bus for one cycle
// after the stage matching the CAS latency. The pipe freezes whenever cke is low.
module sdram_read_pipe
    import sdram_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cke,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [1:0]            cas_latency,
    output logic                  dq_oe,
    output logic [DATA_WIDTH-1:0] dq_out
);

    logic [PIPE_DEPTH-1:0] vld;
    logic [DATA_WIDTH-1:0] data [PIPE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                data[i] <= '0;
            end
        end else if (cke) begin
            vld     <= {vld[PIPE_DEPTH-2:0], push};
            data[0] <= push_data;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                data[i] <= data[i-1];
            end
        end
    end

    // Stage k holds a word k+1 edges after its READ, so CL selects stage CL-1.
    always_comb begin
        dq_oe  = vld[1];
        dq_out = data[1];
        if (cas_latency == 2'd3) begin
            dq_oe  = vld[2];
            dq_out = data[2];
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// Cycle-accurate single-port SDRAM device model: init sequencing, per-bank open rows,
// CAS-latency read return and sticky protocol-error reporting.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int ROW_WIDTH      = 13,
    parameter int COL_WIDTH      = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_if.slave                bus,
    inout  wire  [DATA_WIDTH-1:0] sdram_dq,
    output logic                  init_done,
    output logic [1:0]            cas_latency,
    output logic                  err,
    output logic [2:0]            err_code,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic                  dq_oe,
    output sdram_init_state_t     init_state
);

    logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

    sdram_init_state_t     state, nxt_state;
    sdram_cmd_t            cmd;
    sdram_err_t            err_val;
    logic [NUM_BANKS-1:0]  bank_open;
    logic [ROW_WIDTH-1:0]  open_row [NUM_BANKS];
    logic [1:0]            ba;
    logic                  a10, bank_hit, is_nop;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic                  do_open, do_close_bank, do_close_all, do_write, do_read, do_mode, err_req;
    logic [DATA_WIDTH-1:0] pipe_out;

    // With cke low or cs_n high nothing is decoded; everything collapses to NOP.
    assign cmd = (bus.sdram_cke && !bus.sdram_cs_n)
               ? sdram_cmd_t'({bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n})
               : CMD_NOP;
    assign is_nop   = (cmd == CMD_NOP) || (cmd == CMD_RSVD);
    assign ba       = bus.sdram_ba;
    assign a10      = bus.sdram_addr[10];
    assign bank_hit = bank_open[ba];
    assign mem_idx  = MEM_ADDR_WIDTH'({ba, open_row[ba], bus.sdram_addr[COL_WIDTH-1:0]});

    always_comb begin
        nxt_state     = state;
        do_open       = 1'b0;
        do_close_bank = 1'b0;
        do_close_all  = 1'b0;
        do_write      = 1'b0;
        do_read       = 1'b0;
        do_mode       = 1'b0;
        err_req       = 1'b0;
        err_val       = ERR_NONE;
        case (state)
            ST_WAIT_PRE: begin
                if (cmd == CMD_PRE && a10) begin
                    nxt_state    = ST_WAIT_REF1;
                    do_close_all = 1'b1;
                end else if (!is_nop) begin
                    err_req = 1'b1;
                    err_val = ERR_PRE_INIT;
                end
            end
            ST_WAIT_REF1, ST_WAIT_REF2: begin
                if (cmd == CMD_REF) begin
                    nxt_state = (state == ST_WAIT_REF1) ? ST_WAIT_REF2 : ST_WAIT_MODE;
                end else if (!is_nop) begin
                    err_req = 1'b1;
                    err_val = ERR_PRE_INIT;
                end
            end
            ST_WAIT_MODE: begin
                if (cmd == CMD_MODE) begin
                    if (mode_ok(bus.sdram_addr)) begin
                        do_mode   = 1'b1;
                        nxt_state = ST_READY;
                    end else begin
                        err_req = 1'b1;
                        err_val = ERR_BAD_MODE;
                    end
                end else if (!is_nop) begin
                    err_req = 1'b1;
                    err_val = ERR_PRE_INIT;
                end
            end
            ST_READY: begin
                case (cmd)
                    CMD_ACT: begin
                        if (bank_hit) begin
                            err_req = 1'b1;
                            err_val = ERR_ROW_OPEN;
                        end else begin
                            do_open = 1'b1;
                        end
                    end
                    CMD_PRE: begin
                        do_close_all  = a10;
                        do_close_bank = !a10;
                    end
                    CMD_REF: begin
                        if (|bank_open) begin
                            err_req = 1'b1;
                            err_val = ERR_OPEN_BANKS;
                        end
                    end
                    CMD_MODE: begin
                        err_req = 1'b1;
                        if (|bank_open) begin
                            err_val = ERR_OPEN_BANKS;
                        end else if (mode_ok(bus.sdram_addr)) begin
                            err_req = 1'b0;
                            do_mode = 1'b1;
                        end else begin
                            err_val = ERR_BAD_MODE;
                        end
                    end
                    CMD_WRITE, CMD_READ: begin
                        if (!bank_hit) begin
                            err_req = 1'b1;
                            err_val = ERR_NO_ROW;
                        end else begin
                            do_write = (cmd == CMD_WRITE);
                            do_read  = (cmd == CMD_READ);
                        end
                    end
                    default: ;
                endcase
            end
            default: nxt_state = ST_WAIT_PRE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT_PRE;
            init_done   <= 1'b0;
            cas_latency <= 2'd2;
            err         <= 1'b0;
            err_code    <= 3'd0;
            rd_count    <= 32'd0;
            wr_count    <= 32'd0;
            bank_open   <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            state <= nxt_state;
            if (do_mode) begin
                cas_latency <= bus.sdram_addr[5:4];
                init_done   <= 1'b1;
            end
            if (do_open) begin
                bank_open[ba] <= 1'b1;
                open_row[ba]  <= bus.sdram_addr[ROW_WIDTH-1:0];
            end
            if (do_close_all) begin
                bank_open <= '0;
            end else if (do_close_bank || ((do_write || do_read) && a10)) begin
                bank_open[ba] <= 1'b0;
            end
            if (do_write) wr_count <= wr_count + 32'd1;
            if (do_read)  rd_count <= rd_count + 32'd1;
            // Only the first error is recorded.
            if (err_req && !err) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
        end
    end

    // Storage survives reset; each byte lane has its own write strobe.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (!bus.sdram_dqm[1]) mem[mem_idx][DATA_WIDTH-1:DATA_WIDTH/2] <= sdram_dq[DATA_WIDTH-1:DATA_WIDTH/2];
            if (!bus.sdram_dqm[0]) mem[mem_idx][DATA_WIDTH/2-1:0] <= sdram_dq[DATA_WIDTH/2-1:0];
        end
    end

    sdram_read_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_read_pipe (
        .clk         (clk),
        .rst         (rst),
        .cke         (bus.sdram_cke),
        .push        (do_read),
        .push_data   (mem[mem_idx]),
        .cas_latency (cas_latency),
        .dq_oe       (dq_oe),
        .dq_out      (pipe_out)
    );

    assign sdram_dq   = dq_oe ? pipe_out : {DATA_WIDTH{1'bz}};
    assign init_state = state;

endmodule
